// File: rtl/player_mover.sv
// Player sprite mover: turns per-axis direction codes into a clamped sprite position
// on a fixed movement tick, and tracks the idle/play/hit/win game state.
module player_mover #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int SPRITE_SIZE = 16,
    parameter int START_X     = 16,
    parameter int START_Y     = 16,
    parameter int STEP        = 2,
    parameter int TICK_DIV    = 1666667
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] dir_x,
    input  logic [3:0] dir_y,
    input  logic       start,
    input  logic       restart,
    input  logic       wall_hit,
    input  logic       goal_hit,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic [1:0] game_state,
    output logic       moved,
    output logic [3:0] hit_count
);

    localparam int              CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [10:0]     STEP_W   = 11'(STEP);
    localparam logic [10:0]     MAX_X    = 11'(SCREEN_W - SPRITE_SIZE);
    localparam logic [10:0]     MAX_Y    = 11'(SCREEN_H - SPRITE_SIZE);
    localparam logic [9:0]      X0       = 10'(START_X);
    localparam logic [9:0]      Y0       = 10'(START_Y);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_HIT  = 2'b10,
        S_WIN  = 2'b11
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [9:0]       pos_x_q, pos_y_q;
    logic [9:0]       pos_x_d, pos_y_d;
    logic             moved_q;
    logic [3:0]       hit_q;
    logic             tick;

    // 11-bit arithmetic so pos+STEP cannot wrap before the edge clamp.
    function automatic logic [9:0] axis_step(input logic [9:0] p,
                                             input logic [3:0] d,
                                             input logic [10:0] maxp);
        logic [10:0] p11;
        logic [10:0] sum;
        p11 = {1'b0, p};
        sum = p11 + STEP_W;
        case (d)
            4'b1000: return (p11 < STEP_W) ? '0 : 10'(p11 - STEP_W);
            4'b0010: return (sum > maxp) ? 10'(maxp) : 10'(sum);
            default: return p;
        endcase
    endfunction

    always_comb begin
        tick    = (state_q == S_PLAY) && (cnt_q == CNT_LAST);
        pos_x_d = axis_step(pos_x_q, dir_x, MAX_X);
        pos_y_d = axis_step(pos_y_q, dir_y, MAX_Y);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pos_x_q <= X0;
            pos_y_q <= Y0;
            moved_q <= 1'b0;
            hit_q   <= '0;
        end else begin
            moved_q <= 1'b0;
            if (restart) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                pos_x_q <= X0;
                pos_y_q <= Y0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        cnt_q <= '0;
                        if (start) state_q <= S_PLAY;
                    end
                    S_PLAY: begin
                        // A collision wins over a coincident tick, so the sprite never moves into the hit.
                        if (wall_hit) begin
                            state_q <= S_HIT;
                            cnt_q   <= '0;
                            if (hit_q != 4'hF) hit_q <= hit_q + 4'd1;
                        end else if (goal_hit) begin
                            state_q <= S_WIN;
                            cnt_q   <= '0;
                        end else if (tick) begin
                            cnt_q   <= '0;
                            pos_x_q <= pos_x_d;
                            pos_y_q <= pos_y_d;
                            moved_q <= (pos_x_d != pos_x_q) || (pos_y_d != pos_y_q);
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: cnt_q <= '0;
                endcase
            end
        end
    end

    assign pos_x      = pos_x_q;
    assign pos_y      = pos_y_q;
    assign game_state = state_q;
    assign moved      = moved_q;
    assign hit_count  = hit_q;

endmodule

// File: tb/tb_player_mover.sv
// Scoreboard bench for player_mover: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_player_mover;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] a_dx, a_dy, b_dx, b_dy;
    logic       a_start, a_restart, a_wall, a_goal;
    logic       b_start, b_restart, b_wall, b_goal;
    logic [9:0] a_px, a_py, b_px, b_py;
    logic [1:0] a_st, b_st;
    logic       a_mv, b_mv;
    logic [3:0] a_hc, b_hc;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int    cyc;
        int    id;
        string name;
        int    x, y, st, mv, hc;
    } exp_t;
    exp_t sb[$];

    player_mover #(.TICK_DIV(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .dir_x(a_dx), .dir_y(a_dy),
        .start(a_start), .restart(a_restart), .wall_hit(a_wall), .goal_hit(a_goal),
        .pos_x(a_px), .pos_y(a_py), .game_state(a_st), .moved(a_mv), .hit_count(a_hc)
    );

    player_mover #(.TICK_DIV(4), .START_X(620)) dut_b (
        .clk(clk), .rst_n(rst_n), .dir_x(b_dx), .dir_y(b_dy),
        .start(b_start), .restart(b_restart), .wall_hit(b_wall), .goal_hit(b_goal),
        .pos_x(b_px), .pos_y(b_py), .game_state(b_st), .moved(b_mv), .hit_count(b_hc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input int id, input string name, input int x, input int y,
                              input int st, input int mv, input int hc);
        exp_t e;
        e.cyc = cyc; e.id = id; e.name = name;
        e.x = x; e.y = y; e.st = st; e.mv = mv; e.hc = hc;
        sb.push_back(e);
    endtask

    // Monitor: compares every scoreboard entry due at this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            int ax, ay, ast, amv, ahc;
            e = sb.pop_front();
            if (e.id == 0) begin
                ax = a_px; ay = a_py; ast = a_st; amv = a_mv; ahc = a_hc;
            end else begin
                ax = b_px; ay = b_py; ast = b_st; amv = b_mv; ahc = b_hc;
            end
            checks++;
            if (e.cyc != cyc || ax != e.x || ay != e.y || ast != e.st || amv != e.mv || ahc != e.hc) begin
                errors++;
                $display("FAIL %s (dut%0d cyc %0d/%0d): got x=%0d y=%0d st=%0d mv=%0d hc=%0d, want x=%0d y=%0d st=%0d mv=%0d hc=%0d",
                         e.name, e.id, cyc, e.cyc, ax, ay, ast, amv, ahc, e.x, e.y, e.st, e.mv, e.hc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Second instance: right-edge clamp starting at x=620.
    initial begin
        b_dx = 4'b0000; b_dy = 4'b0000;
        b_start = 1'b0; b_restart = 1'b0; b_wall = 1'b0; b_goal = 1'b0;
        @(posedge rst_n);
        b_start = 1'b1; b_dx = 4'b0010;
        step(1); expect_out(1, "b_enter_play", 620, 16, 1, 0, 0);
        step(4); expect_out(1, "b_tick1", 622, 16, 1, 1, 0);
        step(4); expect_out(1, "b_tick2_clamp", 624, 16, 1, 1, 0);
        step(4); expect_out(1, "b_held_at_edge", 624, 16, 1, 0, 0);
        step(4); expect_out(1, "b_still_held", 624, 16, 1, 0, 0);
    end

    initial begin
        rst_n = 1'b0;
        a_dx = 4'b0000; a_dy = 4'b0000;
        a_start = 1'b0; a_restart = 1'b0; a_wall = 1'b0; a_goal = 1'b0;
        step(2); expect_out(0, "reset", 16, 16, 0, 0, 0);
        expect_out(1, "b_reset", 620, 16, 0, 0, 0);

        rst_n = 1'b1; a_start = 1'b1; a_dx = 4'b1000;
        step(1); expect_out(0, "enter_play", 16, 16, 1, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            step(3); expect_out(0, "between_ticks", 16 - 2 * (k - 1), 16, 1, 0, 0);
            step(1); expect_out(0, "left_tick", 16 - 2 * k, 16, 1, 1, 0);
        end
        step(1); expect_out(0, "moved_one_cycle", 0, 16, 1, 0, 0);
        step(3); expect_out(0, "left_clamp_zero", 0, 16, 1, 0, 0);
        step(4); expect_out(0, "left_clamp_hold", 0, 16, 1, 0, 0);

        a_dx = 4'b0010;
        step(4); expect_out(0, "right_from_zero", 2, 16, 1, 1, 0);
        a_dx = 4'b1010;
        step(4); expect_out(0, "multibit_no_move", 2, 16, 1, 0, 0);
        a_dx = 4'b0000;
        step(4); expect_out(0, "zero_code_no_move", 2, 16, 1, 0, 0);

        a_dy = 4'b0010;
        step(3); a_wall = 1'b1;
        step(1); expect_out(0, "wall_on_tick", 2, 16, 2, 0, 1);
        a_wall = 1'b0; a_dx = 4'b0010;
        step(8); expect_out(0, "hit_frozen", 2, 16, 2, 0, 1);

        a_start = 1'b0; a_dx = 4'b0000; a_dy = 4'b0000; a_restart = 1'b1;
        step(1); a_restart = 1'b0; expect_out(0, "restart_idle", 16, 16, 0, 0, 1);
        step(2); expect_out(0, "idle_waits_start", 16, 16, 0, 0, 1);

        a_start = 1'b1; a_dx = 4'b0010;
        step(1); expect_out(0, "replay", 16, 16, 1, 0, 1);
        step(3); expect_out(0, "counter_cleared", 16, 16, 1, 0, 1);
        step(1); expect_out(0, "right_tick", 18, 16, 1, 1, 1);

        a_start = 1'b0; a_wall = 1'b1; a_goal = 1'b1;
        step(1); expect_out(0, "wall_and_goal_hit", 18, 16, 2, 0, 2);
        a_wall = 1'b0; a_goal = 1'b0; a_dx = 4'b0000;

        a_restart = 1'b1; step(1); a_restart = 1'b0;
        a_start = 1'b1; step(1); a_start = 1'b0;
        a_goal = 1'b1;
        step(1); expect_out(0, "goal_win", 16, 16, 3, 0, 2);
        a_goal = 1'b0;
        step(2); expect_out(0, "win_frozen", 16, 16, 3, 0, 2);

        for (int i = 0; i < 14; i++) begin
            a_restart = 1'b1; step(1); a_restart = 1'b0;
            a_start = 1'b1; step(1); a_start = 1'b0;
            a_wall = 1'b1;
            step(1); expect_out(0, "hit_count_sat", 16, 16, 2, 0, (3 + i > 15) ? 15 : 3 + i);
            a_wall = 1'b0;
        end

        a_restart = 1'b1; step(1); a_restart = 1'b0;
        expect_out(0, "restart_after_sat", 16, 16, 0, 0, 15);
        a_start = 1'b1; a_dx = 4'b0010;
        step(1); expect_out(0, "play_before_reset", 16, 16, 1, 0, 15);
        step(3); rst_n = 1'b0;
        step(1); expect_out(0, "reset_mid_play", 16, 16, 0, 0, 0);
        rst_n = 1'b1; a_start = 1'b0;

        step(2);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
